// File: rtl/or3_x4.sv
// Three-input OR with registered copy, rising-edge pulse, saturating high-cycle
// counter and an optional sticky input-combination mask (macro OR3_X4_COVER_EN).
module or3_x4 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             clr,
    output logic             ZN,
    output logic             zn_q,
    output logic             zn_rise,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [7:0]       cov
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_zn_q;
    logic             r_zn_rise;
    logic [CNT_W-1:0] r_hi_cnt;
    logic             w_cnt_sat;

    // Plain OR so X/Z propagates with normal Verilog semantics.
    assign ZN        = A1 | A2 | A3;
    assign w_cnt_sat = (r_hi_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zn_q    <= 1'b0;
            r_zn_rise <= 1'b0;
        end else begin
            r_zn_q    <= ZN;
            r_zn_rise <= ZN & ~r_zn_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt <= '0;
        end else if (clr) begin
            r_hi_cnt <= '0;
        end else if (ZN && !w_cnt_sat) begin
            r_hi_cnt <= r_hi_cnt + 1'b1;
        end
    end

`ifdef OR3_X4_COVER_EN
    logic [7:0] r_cov;
    logic [2:0] w_idx;

    assign w_idx = {A1, A2, A3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cov <= 8'h00;
        end else if (clr) begin
            r_cov <= 8'h00;
        end else begin
            r_cov[w_idx] <= 1'b1;
        end
    end

    assign cov = r_cov;
`else
    assign cov = 8'h00;
`endif

    assign zn_q    = r_zn_q;
    assign zn_rise = r_zn_rise;
    assign hi_cnt  = r_hi_cnt;

endmodule

// File: tb/tb_or3_x4.sv
// Scoreboard bench for or3_x4 (CNT_W=4): driver pushes expected outputs,
// a monitor pops and compares one cycle after each driven edge.
module tb_or3_x4;

  localparam int CNT_W = 4;
  localparam int EW    = 3 + CNT_W + 8;

  logic             clk;
  logic             rst_n;
  logic             a1, a2, a3;
  logic             clr;
  logic             zn;
  logic             zn_q;
  logic             zn_rise;
  logic [CNT_W-1:0] hi_cnt;
  logic [7:0]       cov;

  int checks;
  int failures;

  logic [EW-1:0] exp_q[$];

  // reference state
  logic             m_zn_q;
  logic             m_rise;
  logic [CNT_W-1:0] m_cnt;
  logic [7:0]       m_cov;

  or3_x4 #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A1      (a1),
    .A2      (a2),
    .A3      (a3),
    .clr     (clr),
    .ZN      (zn),
    .zn_q    (zn_q),
    .zn_rise (zn_rise),
    .hi_cnt  (hi_cnt),
    .cov     (cov)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_zn_q = 1'b0;
    m_rise = 1'b0;
    m_cnt  = '0;
    m_cov  = 8'h00;
  endtask

  // driver: apply one input vector for the next rising edge and push the result
  task automatic cycle(input logic [2:0] a, input logic c);
    logic m_zn;
    @(negedge clk);
    {a1, a2, a3} = a;
    clr = c;
    m_zn   = (a != 3'b000);
    m_rise = m_zn & ~m_zn_q;
    m_zn_q = m_zn;
    if (c) begin
      m_cnt = '0;
      m_cov = 8'h00;
    end else begin
      if (m_zn && m_cnt != 4'hF) m_cnt = m_cnt + 1'b1;
`ifdef OR3_X4_COVER_EN
      m_cov[a] = 1'b1;
`endif
    end
    exp_q.push_back({m_zn, m_zn_q, m_rise, m_cnt, m_cov});
  endtask

  // monitor
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("zn",      {31'd0, zn},      {31'd0, e[EW-1]});
      check("zn_q",    {31'd0, zn_q},    {31'd0, e[EW-2]});
      check("zn_rise", {31'd0, zn_rise}, {31'd0, e[EW-3]});
      check("hi_cnt",  {28'd0, hi_cnt},  {28'd0, e[CNT_W+7:8]});
      check("cov",     {24'd0, cov},     {24'd0, e[7:0]});
    end
  end

  logic [7:0] tt_exp;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    {a1, a2, a3} = 3'b000;
    model_reset();

    // truth table while held in reset: ZN stays combinational
    tt_exp = 8'b1111_1110;
    for (int i = 0; i < 8; i++) begin
      {a1, a2, a3} = i[2:0];
      #15;
      check("truth_table", {31'd0, zn}, {31'd0, tt_exp[i]});
    end
    check("reset_zn_q",    {31'd0, zn_q},    32'd0);
    check("reset_zn_rise", {31'd0, zn_rise}, 32'd0);
    check("reset_hi_cnt",  {28'd0, hi_cnt},  32'd0);
    check("reset_cov",     {24'd0, cov},     32'd0);

    @(negedge clk);
    {a1, a2, a3} = 3'b000;
    rst_n = 1'b1;

    // registered path: 000,000,001 -> zn_q=1, zn_rise pulse, hi_cnt=1
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b001, 1'b0);
    cycle(3'b001, 1'b0);
    cycle(3'b000, 1'b0);

    // coverage sweep then clear (with and without ZN high during clr)
    for (int i = 0; i < 8; i++) cycle(i[2:0], 1'b0);
    @(posedge clk);
    #2;
`ifdef OR3_X4_COVER_EN
    check("cov_full", {24'd0, cov}, 32'h0000_00FF);
`else
    check("cov_full", {24'd0, cov}, 32'h0000_0000);
`endif
    cycle(3'b000, 1'b1);
    cycle(3'b101, 1'b0);
    cycle(3'b111, 1'b1);

    // saturation
    for (int i = 0; i < 20; i++) cycle(3'b111, 1'b0);
    @(posedge clk);
    #2;
    check("hi_cnt_sat", {28'd0, hi_cnt}, 32'd15);

    // build hi_cnt=5, zn_q=1, then async reset between edges
    cycle(3'b111, 1'b1);
    for (int i = 0; i < 5; i++) cycle(3'b010, 1'b0);
    @(posedge clk);
    #3;
    check("pre_rst_hi_cnt", {28'd0, hi_cnt}, 32'd5);
    check("pre_rst_zn_q",   {31'd0, zn_q},   32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_zn_q",    {31'd0, zn_q},    32'd0);
    check("arst_zn_rise", {31'd0, zn_rise}, 32'd0);
    check("arst_hi_cnt",  {28'd0, hi_cnt},  32'd0);
    check("arst_cov",     {24'd0, cov},     32'd0);
    check("arst_zn_hi",   {31'd0, zn},      32'd1);
    {a1, a2, a3} = 3'b000;
    #1;
    check("arst_zn_lo",   {31'd0, zn},      32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // first ZN=1 edge after reset must pulse zn_rise
    cycle(3'b100, 1'b0);
    cycle(3'b100, 1'b0);
    cycle(3'b000, 1'b0);

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/or3_x4.md
OR3_X4 -- requirements
Module: or3_x4

Interface
REQ-001 Parameter CNT_W, default 16, width of the high-cycle counter; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 A1  input  1  OR operand 1.
REQ-005 A2  input  1  OR operand 2.
REQ-006 A3  input  1  OR operand 3.
REQ-007 clr  input  1  synchronous clear of counter and coverage state, active-high.
REQ-008 ZN  output  1  combinational A1|A2|A3.
REQ-009 zn_q  output  1  ZN registered one cycle.
REQ-010 zn_rise  output  1  one-cycle pulse on a registered 0->1 transition of ZN.
REQ-011 hi_cnt  output  CNT_W  saturating count of cycles with ZN=1.
REQ-012 cov  output  8  sticky input-combination coverage mask.

Function
REQ-013 ZN SHALL equal A1|A2|A3 at all times, with zero latency and no dependence on clk, rst_n or clr: 000->0; every other combination (001..111)->1.
REQ-014 zn_q SHALL take the value of ZN at each rising clk edge (latency 1 cycle).
REQ-015 zn_rise SHALL be 1 for exactly the cycle after an edge where ZN=1 and the previous zn_q=0; it is registered.
REQ-016 hi_cnt SHALL increment by 1 on each rising edge where ZN=1, saturate at 2^CNT_W-1, and hold at saturation.
REQ-017 cov bit index {A1,A2,A3} (A1 as MSB) SHALL be set on each rising edge where that combination is present; bits never clear except via clr or reset.
REQ-018 clr=1 on an edge SHALL zero hi_cnt and cov; clr takes priority over increment/set in the same cycle; zn_q and zn_rise are unaffected by clr.
REQ-019 X/Z on any A input SHALL NOT be masked: ZN follows standard Verilog OR semantics (1 dominates X).

Reset
REQ-020 rst_n=0 SHALL immediately force zn_q=0, zn_rise=0, hi_cnt=0, cov=0, regardless of clk.
REQ-021 ZN SHALL remain combinational A1|A2|A3 during reset.
REQ-022 After rst_n deasserts, the first rising edge with ZN=1 SHALL produce zn_rise=1 (previous zn_q=0 from reset).
REQ-023 Reset asserted mid-count SHALL discard the count; no partial state is retained.

Configuration
REQ-024 Macro OR3_X4_COVER_EN: when defined, the cov logic of REQ-017/018 is compiled in.
REQ-025 When OR3_X4_COVER_EN is undefined, the cov port SHALL still exist and be driven constant 8'h00, with no coverage flops synthesized.

Verification
REQ-026 Exhaustive truth table: apply A1A2A3 = 000..111, 15-time-unit holds -> ZN = 0,1,1,1,1,1,1,1.
REQ-027 Registered path: A=000 for 2 cycles, then 001 -> zn_q=1 one cycle later, zn_rise=1 for exactly that one cycle, hi_cnt=1.
REQ-028 Saturation, CNT_W=4: hold A=111 for 20 cycles -> hi_cnt reaches 15 and stays 15.
REQ-029 Coverage, macro defined: sweep all 8 combinations once -> cov=8'hFF; then clr=1 for one cycle -> cov=8'h00, hi_cnt=0; macro undefined -> cov=8'h00 throughout.
REQ-030 Async reset: with hi_cnt=5 and zn_q=1, drop rst_n between clk edges -> zn_q, zn_rise, hi_cnt, cov = 0 immediately, while ZN still tracks inputs.
